fp_mul_norm_round: RTL and testbench

FP_MUL_NORM_ROUND -- requirements
Module: fp_mul_norm_round

---
 rtl/fp_mul_norm_round.sv | 185 ++++++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_round.sv
`timescale 1ns/1ps
// Normalize, round-to-nearest-even and pack the mantissa array product of a
// single-precision multiply; unpack sideband is delayed to line up with the product.
module fp_mul_norm_round #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iValid,
    input  logic        iSign,
    input  logic [9:0]  iExp,
    input  logic        iNaN,
    input  logic        iInf,
    input  logic        iZero,
    input  logic        iInvalid,
    input  logic [63:0] iProduct,
    output logic        oValid,
    output logic [31:0] oZ,
    output logic [3:0]  oFlags
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic       valid;
        logic       sign;
        logic [9:0] exp;
        logic       nan;
        logic       inf;
        logic       zero;
        logic       invalid;
    } side_t;

    typedef struct packed {
        logic        valid;
        logic        sign;
        logic [9:0]  exp;
        logic [22:0] mant;
        logic        guard;
        logic        sticky;
        logic        nan;
        logic        inf;
        logic        zero;
        logic        invalid;
    } norm_t;

    side_t side_d [MUL_LAT];
    side_t side_q [MUL_LAT];
    side_t side_tail;

    norm_t norm_d;
    norm_t norm_q;

    logic [47:0] prod;
    logic        unused_prod_hi;

    logic        round_up;
    logic [23:0] mant_rnd;
    logic [9:0]  exp_rnd;
    logic        inexact;
    logic        ovf;
    logic        unf;

    logic        valid_d, valid_q;
    logic [31:0] z_d, z_q;
    logic [3:0]  flags_d, flags_q;

    assign prod           = iProduct[47:0];
    assign unused_prod_hi = ^iProduct[63:48];

    // Sideband delay line
    always_comb begin
        side_d[0].valid   = iValid;
        side_d[0].sign    = iSign;
        side_d[0].exp     = iExp;
        side_d[0].nan     = iNaN;
        side_d[0].inf     = iInf;
        side_d[0].zero    = iZero;
        side_d[0].invalid = iInvalid;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            side_d[i] = side_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                side_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                side_q[i] <= side_d[i];
            end
        end
    end

    assign side_tail = side_q[MUL_LAT-1];

    // Stage N: pick the leading one (bit 47 or 46) and split guard/sticky
    always_comb begin
        norm_d       = norm_q;
        norm_d.valid = side_tail.valid;
        if (side_tail.valid) begin
            norm_d.sign    = side_tail.sign;
            norm_d.nan     = side_tail.nan;
            norm_d.inf     = side_tail.inf;
            norm_d.zero    = side_tail.zero;
            norm_d.invalid = side_tail.invalid;
            if (prod[47]) begin
                norm_d.mant   = prod[46:24];
                norm_d.guard  = prod[23];
                norm_d.sticky = |prod[22:0];
                norm_d.exp    = side_tail.exp + 10'd1;
            end else begin
                norm_d.mant   = prod[45:23];
                norm_d.guard  = prod[22];
                norm_d.sticky = |prod[21:0];
                norm_d.exp    = side_tail.exp;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            norm_q <= '0;
        end else begin
            norm_q <= norm_d;
        end
    end

    // Stage R: round, then range-check the post-round exponent as signed
    always_comb begin
        round_up = norm_q.guard & (norm_q.sticky | norm_q.mant[0]);
        mant_rnd = {1'b0, norm_q.mant} + {23'd0, round_up};
        exp_rnd  = norm_q.exp + {9'd0, mant_rnd[23]};
        inexact  = norm_q.guard | norm_q.sticky;
        ovf      = $signed(exp_rnd) >= 10'sd255;
        unf      = $signed(exp_rnd) <= 10'sd0;
    end

    always_comb begin
        valid_d = norm_q.valid;
        z_d     = z_q;
        flags_d = flags_q;
        if (norm_q.valid) begin
            flags_d = {norm_q.invalid, 3'b000};
            if (norm_q.invalid || norm_q.nan) begin
                z_d = QNAN;
            end else if (norm_q.inf) begin
                z_d = {norm_q.sign, 8'hFF, 23'd0};
            end else if (norm_q.zero) begin
                z_d = {norm_q.sign, 31'd0};
            end else if (ovf) begin
                z_d        = {norm_q.sign, 8'hFF, 23'd0};
                flags_d[2] = 1'b1;
                flags_d[0] = 1'b1;
            end else if (unf) begin
                z_d        = {norm_q.sign, 31'd0};
                flags_d[1] = 1'b1;
                flags_d[0] = 1'b1;
            end else begin
                // a rounding carry leaves mant_rnd[22:0] all zero
                z_d        = {norm_q.sign, exp_rnd[7:0], mant_rnd[22:0]};
                flags_d[0] = inexact;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            z_q     <= '0;
            flags_q <= '0;
        end else begin
            valid_q <= valid_d;
            z_q     <= z_d;
            flags_q <= flags_d;
        end
    end

    assign oValid = valid_q;
    assign oZ     = z_q;
    assign oFlags = flags_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
`timescale 1ns/1ps
// Directed bench for fp_mul_norm_round: latency, rounding, range limits,
// specials, streaming with bubbles and mid-flight reset.
module tb_fp_mul_norm_round;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iValid;
    logic        iSign;
    logic [9:0]  iExp;
    logic        iNaN;
    logic        iInf;
    logic        iZero;
    logic        iInvalid;
    logic [63:0] iProduct;
    logic        oValid;
    logic [31:0] oZ;
    logic [3:0]  oFlags;

    int n_cmp  = 0;
    int n_fail = 0;

    fp_mul_norm_round #(.MUL_LAT(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .iValid   (iValid),
        .iSign    (iSign),
        .iExp     (iExp),
        .iNaN     (iNaN),
        .iInf     (iInf),
        .iZero    (iZero),
        .iInvalid (iInvalid),
        .iProduct (iProduct),
        .oValid   (oValid),
        .oZ       (oZ),
        .oFlags   (oFlags)
    );

    always #5 clk = ~clk;

    // fl = {nan, inf, zero, invalid}
    task automatic drive_side(input logic v, input logic s, input logic [9:0] e, input logic [3:0] fl);
        iValid   = v;
        iSign    = s;
        iExp     = e;
        iNaN     = fl[3];
        iInf     = fl[2];
        iZero    = fl[1];
        iInvalid = fl[0];
    endtask

    // Issue one operation now (caller sits just after a rising edge), product
    // four cycles later, then watch 12 cycles for the result.
    task automatic run_one(input logic s, input logic [9:0] e, input logic [3:0] fl,
                           input logic [63:0] p, output int lat, output int np,
                           output logic [31:0] z, output logic [3:0] f);
        lat = -1;
        np  = 0;
        z   = '0;
        f   = '0;
        drive_side(1'b1, s, e, fl);
        iProduct = {$urandom(), $urandom()};
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (oValid === 1'b1) begin
                np++;
                if (lat < 0) begin
                    lat = c;
                    z   = oZ;
                    f   = oFlags;
                end
            end
            drive_side(1'b0, 1'b0, 10'd0, 4'b0000);
            iProduct = (c == 4) ? p : {$urandom(), $urandom()};
        end
    endtask

    // Reference: integer round-to-nearest-even on the full 48-bit product
    function automatic logic [35:0] model(input logic s, input logic [9:0] e,
                                          input logic [3:0] fl, input logic [63:0] p);
        longint unsigned keep, rem, half;
        int sh, ex;
        logic [31:0] z;
        logic [3:0]  f;
        f = {fl[0], 3'b000};
        if (fl[0] || fl[3]) begin
            z = 32'h7FC0_0000;
        end else if (fl[2]) begin
            z = {s, 8'hFF, 23'd0};
        end else if (fl[1]) begin
            z = {s, 31'd0};
        end else begin
            sh   = p[47] ? 24 : 23;
            ex   = int'($signed(e)) + (p[47] ? 1 : 0);
            keep = p >> sh;
            rem  = p & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
            if (keep == (64'd1 << 24)) begin
                keep = 64'd1 << 23;
                ex   = ex + 1;
            end
            f[0] = (rem != 0);
            if (ex >= 255) begin
                z      = {s, 8'hFF, 23'd0};
                f[2:0] = 3'b101;
            end else if (ex <= 0) begin
                z      = {s, 31'd0};
                f[2:0] = 3'b011;
            end else begin
                z = {s, ex[7:0], keep[22:0]};
            end
        end
        return {f, z};
    endfunction

    task automatic test_reset();
        int lat, np;
        logic [31:0] z;
        logic [3:0]  f;
        resetn = 1'b0;
        drive_side(1'b0, 1'b0, 10'd0, 4'b0000);
        iProduct = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_oValid: got %b want 0", oValid); end
        n_cmp++; if (oZ !== 32'h0) begin n_fail++; $display("FAIL reset_oZ: got %h want 00000000", oZ); end
        n_cmp++; if (oFlags !== 4'h0) begin n_fail++; $display("FAIL reset_oFlags: got %b want 0000", oFlags); end
        // first edge after release samples this operation
        resetn = 1'b1;
        run_one(1'b0, 10'd127, 4'b0000, 64'h0000_9000_0000_0000, lat, np, z, f);
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency: got %0d want 6", lat); end
        n_cmp++; if (np !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", np); end
        n_cmp++; if (z !== 32'h4010_0000) begin n_fail++; $display("FAIL basic_oZ: got %h want 40100000", z); end
        n_cmp++; if (f !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b want 0000", f); end
    endtask

    task automatic test_round();
        int lat, np;
        logic [31:0] z;
        logic [3:0]  f;
        @(posedge clk); #1;
        run_one(1'b0, 10'd127, 4'b0000, 64'h0000_4000_00C0_0000, lat, np, z, f);
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL tie_odd_latency: got %0d want 6", lat); end
        n_cmp++; if (z !== 32'h3F80_0002) begin n_fail++; $display("FAIL tie_odd_oZ: got %h want 3f800002", z); end
        n_cmp++; if (f !== 4'b0001) begin n_fail++; $display("FAIL tie_odd_flags: got %b want 0001", f); end
        @(posedge clk); #1;
        run_one(1'b0, 10'd100, 4'b0000, 64'h0000_FFFF_FF80_0000, lat, np, z, f);
        n_cmp++; if (z !== 32'h3300_0000) begin n_fail++; $display("FAIL round_carry_oZ: got %h want 33000000", z); end
        n_cmp++; if (f !== 4'b0001) begin n_fail++; $display("FAIL round_carry_flags: got %b want 0001", f); end
    endtask

    task automatic test_range();
        int lat, np;
        logic [31:0] z;
        logic [3:0]  f;
        @(posedge clk); #1;
        run_one(1'b0, 10'd254, 4'b0000, 64'h0000_8000_0000_0000, lat, np, z, f);
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL overflow_latency: got %0d want 6", lat); end
        n_cmp++; if (z !== 32'h7F80_0000) begin n_fail++; $display("FAIL overflow_oZ: got %h want 7f800000", z); end
        n_cmp++; if (f !== 4'b0101) begin n_fail++; $display("FAIL overflow_flags: got %b want 0101", f); end
        @(posedge clk); #1;
        run_one(1'b1, 10'h3FB, 4'b0000, 64'h0000_4000_0000_0000, lat, np, z, f);
        n_cmp++; if (z !== 32'h8000_0000) begin n_fail++; $display("FAIL underflow_oZ: got %h want 80000000", z); end
        n_cmp++; if (f !== 4'b0011) begin n_fail++; $display("FAIL underflow_flags: got %b want 0011", f); end
    endtask

    task automatic test_specials();
        int lat, np;
        logic [31:0] z;
        logic [3:0]  f;
        @(posedge clk); #1;
        run_one(1'b0, 10'd300, 4'b1001, 64'h0000_8000_0000_0000, lat, np, z, f);
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL nan_latency: got %0d want 6", lat); end
        n_cmp++; if (z !== 32'h7FC0_0000) begin n_fail++; $display("FAIL nan_oZ: got %h want 7fc00000", z); end
        n_cmp++; if (f !== 4'b1000) begin n_fail++; $display("FAIL nan_flags: got %b want 1000", f); end
        @(posedge clk); #1;
        run_one(1'b1, 10'd127, 4'b0100, 64'h0000_4000_00C0_0000, lat, np, z, f);
        n_cmp++; if (z !== 32'hFF80_0000) begin n_fail++; $display("FAIL inf_oZ: got %h want ff800000", z); end
        n_cmp++; if (f !== 4'b0000) begin n_fail++; $display("FAIL inf_flags: got %b want 0000", f); end
    endtask

    task automatic test_back_to_back();
        logic        tv [12];
        logic        ts [12];
        logic [9:0]  te [12];
        logic [3:0]  tf [12];
        logic [63:0] tp [12];
        logic [35:0] exp_r;
        logic [31:0] held_z;
        logic [3:0]  held_f;
        int j;
        tv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ts = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        te = '{10'd127, 10'd127, 10'd130, 10'd254, 10'h3FB, 10'd100, 10'd50, 10'd200,
               10'd0, 10'd0, 10'd60, 10'd1};
        tf = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100,
               4'b0000, 4'b0000, 4'b0010, 4'b0000};
        tp = '{64'h0000_9000_0000_0000, 64'h0000_4000_00C0_0000, 64'h0000_5555_5555_5555,
               64'h0000_8000_0000_0000, 64'h0000_4000_0000_0000, 64'h0000_FFFF_FF80_0000,
               64'h0000_8123_4567_89AB, 64'h0000_4000_0000_0000, 64'h0000_0000_0000_0000,
               64'h0000_0000_0000_0000, 64'h0000_7FFF_FFFF_FFFF, 64'h0000_4000_0040_0000};
        held_z = '0;
        held_f = '0;
        @(posedge clk); #1;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            j = c - 6;
            if (j >= 0 && j < 12 && tv[j]) begin
                exp_r  = model(ts[j], te[j], tf[j], tp[j]);
                held_z = exp_r[31:0];
                held_f = exp_r[35:32];
                n_cmp++; if (oValid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid slot %0d: got %b want 1", j, oValid); end
                n_cmp++; if (oZ !== held_z) begin n_fail++; $display("FAIL b2b_oZ slot %0d: got %h want %h", j, oZ, held_z); end
                n_cmp++; if (oFlags !== held_f) begin n_fail++; $display("FAIL b2b_flags slot %0d: got %b want %b", j, oFlags, held_f); end
            end else begin
                n_cmp++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle cycle %0d: got oValid %b want 0", c, oValid); end
                if (j >= 0 && j < 12) begin
                    n_cmp++; if (oZ !== held_z) begin n_fail++; $display("FAIL b2b_hold_oZ slot %0d: got %h want %h", j, oZ, held_z); end
                    n_cmp++; if (oFlags !== held_f) begin n_fail++; $display("FAIL b2b_hold_flags slot %0d: got %b want %b", j, oFlags, held_f); end
                end
            end
            if (c < 12) drive_side(tv[c], ts[c], te[c], tf[c]);
            else        drive_side(1'b0, 1'b0, 10'd0, 4'b0000);
            if (c >= 4 && c < 16 && tv[c-4]) iProduct = tp[c-4];
            else                             iProduct = {$urandom(), $urandom()};
        end
    endtask

    task automatic test_reset_midflight();
        int lat, np, stray;
        logic [31:0] z;
        logic [3:0]  f;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            drive_side(1'b1, 1'b0, 10'd127, 4'b0000);
            @(posedge clk); #1;
        end
        drive_side(1'b0, 1'b0, 10'd0, 4'b0000);
        @(posedge clk); #1;
        iProduct = 64'h0000_9000_0000_0000;
        @(posedge clk); #1;
        // asynchronous: outputs clear between edges
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (oZ !== 32'h0) begin n_fail++; $display("FAIL async_reset_oZ: got %h want 00000000", oZ); end
        n_cmp++; if (oFlags !== 4'h0) begin n_fail++; $display("FAIL async_reset_flags: got %b want 0000", oFlags); end
        @(posedge clk);
        #3 resetn = 1'b1;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (oValid === 1'b1) stray++;
            iProduct = 64'h0000_9000_0000_0000;
        end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL reset_discard: got %0d stray pulses want 0", stray); end
        run_one(1'b0, 10'd127, 4'b0000, 64'h0000_4000_00C0_0000, lat, np, z, f);
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 6", lat); end
        n_cmp++; if (np !== 1) begin n_fail++; $display("FAIL post_reset_pulses: got %0d want 1", np); end
        n_cmp++; if (z !== 32'h3F80_0002) begin n_fail++; $display("FAIL post_reset_oZ: got %h want 3f800002", z); end
    endtask

    initial begin
        test_reset();
        test_round();
        test_range();
        test_specials();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
